// File: rtl/cyclotron_mem_pkg.sv
// Shared width derivations and the memory request record for the Cyclotron
// LSU-to-memory arbiter.
package cyclotron_mem_pkg;

  localparam int DEF_ARCH_LEN  = 32;
  localparam int DEF_LSU_LANES = 16;
  localparam int DEF_TAG_BITS  = 32;

  function automatic int calc_data_w(input int arch_len, input int lsu_lanes);
    return arch_len * lsu_lanes;
  endfunction

  function automatic int calc_mask_w(input int data_w);
    return data_w / 8;
  endfunction

  // A single source still needs one sid bit so the tag layout never collapses.
  function automatic int calc_sid_bits(input int num_srcs);
    return (num_srcs <= 2) ? 1 : $clog2(num_srcs);
  endfunction

  localparam int DEF_DATA_W = calc_data_w(DEF_ARCH_LEN, DEF_LSU_LANES);
  localparam int DEF_MASK_W = calc_mask_w(DEF_DATA_W);

  typedef struct packed {
    logic                    store;
    logic [DEF_ARCH_LEN-1:0] address;
    logic [DEF_TAG_BITS-1:0] tag;
    logic [DEF_DATA_W-1:0]   data;
    logic [DEF_MASK_W-1:0]   mask;
  } mem_req_t;

endpackage

// File: rtl/cyclotron_rr_arbiter.sv
// Round-robin picker: first set request at or after ptr, wrapping, one-hot out.
module cyclotron_rr_arbiter #(
  parameter int NUM_SRCS = 4,
  parameter int PTR_W    = 2
) (
  input  logic [NUM_SRCS-1:0] req,
  input  logic [PTR_W-1:0]    ptr,
  output logic [NUM_SRCS-1:0] grant
);

  int   idx;
  logic found;

  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = 0;
    for (int i = 0; i < NUM_SRCS; i++) begin
      idx = (int'(ptr) + i) % NUM_SRCS;
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cyclotron_mem_arbiter.sv
// Funnels NUM_SRCS LSU request ports into one registered memory port and
// routes tagged responses back to their source by the sid field of the tag.
module cyclotron_mem_arbiter
  import cyclotron_mem_pkg::*;
#(
  parameter int NUM_SRCS        = 4,
  parameter int ARCH_LEN        = 32,
  parameter int LSU_LANES       = 16,
  parameter int SRC_TAG_BITS    = 8,
  parameter int TAG_BITS        = 32,
  parameter int MAX_OUTSTANDING = 8,
  localparam int DATA_W   = calc_data_w(ARCH_LEN, LSU_LANES),
  localparam int MASK_W   = calc_mask_w(DATA_W),
  localparam int SID_BITS = calc_sid_bits(NUM_SRCS)
) (
  input  logic                             clock,
  input  logic                             reset,

  input  logic [NUM_SRCS-1:0]              src_req_valid,
  output logic [NUM_SRCS-1:0]              src_req_ready,
  input  logic [NUM_SRCS-1:0]              src_req_store,
  input  logic [NUM_SRCS*ARCH_LEN-1:0]     src_req_address,
  input  logic [NUM_SRCS*SRC_TAG_BITS-1:0] src_req_tag,
  input  logic [NUM_SRCS*DATA_W-1:0]       src_req_data,
  input  logic [NUM_SRCS*MASK_W-1:0]       src_req_mask,

  output logic [NUM_SRCS-1:0]              src_resp_valid,
  input  logic [NUM_SRCS-1:0]              src_resp_ready,
  output logic [SRC_TAG_BITS-1:0]          src_resp_tag,
  output logic [DATA_W-1:0]                src_resp_data,

  output logic                             mem_req_valid,
  input  logic                             mem_req_ready,
  output logic                             mem_req_store,
  output logic [ARCH_LEN-1:0]              mem_req_address,
  output logic [TAG_BITS-1:0]              mem_req_tag,
  output logic [DATA_W-1:0]                mem_req_data,
  output logic [MASK_W-1:0]                mem_req_mask,

  input  logic                             mem_resp_valid,
  output logic                             mem_resp_ready,
  input  logic [TAG_BITS-1:0]              mem_resp_tag,
  input  logic [DATA_W-1:0]                mem_resp_data,

  output logic                             err_stray
);

  localparam int CNT_W     = $clog2(MAX_OUTSTANDING + 1);
  localparam int REQ_TAG_W = SID_BITS + SRC_TAG_BITS;

  if (REQ_TAG_W > TAG_BITS) begin : g_tag_width_check
    $error("cyclotron_mem_arbiter: SRC_TAG_BITS+SID_BITS exceeds TAG_BITS");
  end

  typedef struct packed {
    logic                store;
    logic [ARCH_LEN-1:0] address;
    logic [TAG_BITS-1:0] tag;
    logic [DATA_W-1:0]   data;
    logic [MASK_W-1:0]   mask;
  } req_t;

  logic [CNT_W-1:0]    outstanding [NUM_SRCS];
  logic [NUM_SRCS-1:0] eligible;
  logic [NUM_SRCS-1:0] arb_req;
  logic [NUM_SRCS-1:0] grant;
  logic [NUM_SRCS-1:0] resp_fire;
  logic [SID_BITS-1:0] rr_ptr;
  logic [SID_BITS-1:0] rr_ptr_nxt;
  logic                load_en;
  logic [SID_BITS-1:0] resp_sid;
  logic                resp_hit;

  req_t req_p0;
  req_t req_p1;
  logic vld_p1;

  // ---- stage p0: eligibility, round-robin pick and payload select ----
  always_comb begin
    eligible = '0;
    for (int k = 0; k < NUM_SRCS; k++) begin
      eligible[k] = src_req_valid[k] && (outstanding[k] < CNT_W'(MAX_OUTSTANDING));
    end
  end

  assign load_en = !vld_p1 || mem_req_ready;
  // Holding off the arbiter in reset keeps src_req_ready low while reset is asserted.
  assign arb_req = (load_en && reset) ? eligible : '0;

  cyclotron_rr_arbiter #(
    .NUM_SRCS (NUM_SRCS),
    .PTR_W    (SID_BITS)
  ) u_rr_arbiter (
    .req   (arb_req),
    .ptr   (rr_ptr),
    .grant (grant)
  );

  assign src_req_ready = grant;

  always_comb begin
    req_p0     = '0;
    rr_ptr_nxt = rr_ptr;
    for (int k = 0; k < NUM_SRCS; k++) begin
      if (grant[k]) begin
        req_p0.store   = src_req_store[k];
        req_p0.address = src_req_address[k*ARCH_LEN +: ARCH_LEN];
        req_p0.tag     = TAG_BITS'({SID_BITS'(k), src_req_tag[k*SRC_TAG_BITS +: SRC_TAG_BITS]});
        req_p0.data    = src_req_data[k*DATA_W +: DATA_W];
        req_p0.mask    = src_req_mask[k*MASK_W +: MASK_W];
        rr_ptr_nxt     = (k == NUM_SRCS - 1) ? '0 : SID_BITS'(k + 1);
      end
    end
  end

  // ---- stage p1: registered memory request ----
  always_ff @(posedge clock) begin
    if (!reset) begin
      vld_p1 <= 1'b0;
      rr_ptr <= '0;
    end else if (load_en) begin
      vld_p1 <= |grant;
      if (|grant) rr_ptr <= rr_ptr_nxt;
    end
  end

  always_ff @(posedge clock) begin
    if (load_en && |grant) req_p1 <= req_p0;
  end

  assign mem_req_valid   = vld_p1;
  assign mem_req_store   = req_p1.store;
  assign mem_req_address = req_p1.address;
  assign mem_req_tag     = req_p1.tag;
  assign mem_req_data    = req_p1.data;
  assign mem_req_mask    = req_p1.mask;

  // Responses for unknown or idle sources are swallowed so memory never stalls on them.
  assign resp_sid = mem_resp_tag[SRC_TAG_BITS +: SID_BITS];

  always_comb begin
    src_resp_valid = '0;
    mem_resp_ready = 1'b1;
    resp_hit       = 1'b0;
    for (int k = 0; k < NUM_SRCS; k++) begin
      if (resp_sid == SID_BITS'(k) && outstanding[k] != '0) begin
        resp_hit          = 1'b1;
        src_resp_valid[k] = mem_resp_valid;
        mem_resp_ready    = src_resp_ready[k];
      end
    end
  end

  assign resp_fire     = src_resp_valid & src_resp_ready;
  assign src_resp_tag  = mem_resp_tag[SRC_TAG_BITS-1:0];
  assign src_resp_data = mem_resp_data;

  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int k = 0; k < NUM_SRCS; k++) outstanding[k] <= '0;
    end else begin
      for (int k = 0; k < NUM_SRCS; k++) begin
        case ({grant[k], resp_fire[k]})
          2'b10:   outstanding[k] <= outstanding[k] + CNT_W'(1);
          2'b01:   outstanding[k] <= outstanding[k] - CNT_W'(1);
          default: outstanding[k] <= outstanding[k];
        endcase
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset)                          err_stray <= 1'b0;
    else if (mem_resp_valid && !resp_hit) err_stray <= 1'b1;
  end

endmodule

// File: tb/tb_cyclotron_mem_arbiter.sv
// Directed bench for cyclotron_mem_arbiter: a 4-source instance plus a
// 3-source instance used for out-of-range response sids.
module tb_cyclotron_mem_arbiter;

  localparam int N  = 4;
  localparam int NB = 3;
  localparam int DW = 512;
  localparam int MW = 64;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  logic [N-1:0]      src_req_valid, src_req_ready, src_req_store;
  logic [N*32-1:0]   src_req_address;
  logic [N*8-1:0]    src_req_tag;
  logic [N*DW-1:0]   src_req_data;
  logic [N*MW-1:0]   src_req_mask;
  logic [N-1:0]      src_resp_valid, src_resp_ready;
  logic [7:0]        src_resp_tag;
  logic [DW-1:0]     src_resp_data;
  logic              mem_req_valid, mem_req_ready, mem_req_store;
  logic [31:0]       mem_req_address, mem_req_tag;
  logic [DW-1:0]     mem_req_data;
  logic [MW-1:0]     mem_req_mask;
  logic              mem_resp_valid, mem_resp_ready;
  logic [31:0]       mem_resp_tag;
  logic [DW-1:0]     mem_resp_data;
  logic              err_stray;

  logic [NB-1:0]     b_src_req_valid, b_src_req_ready, b_src_req_store;
  logic [NB*32-1:0]  b_src_req_address;
  logic [NB*8-1:0]   b_src_req_tag;
  logic [NB*DW-1:0]  b_src_req_data;
  logic [NB*MW-1:0]  b_src_req_mask;
  logic [NB-1:0]     b_src_resp_valid, b_src_resp_ready;
  logic [7:0]        b_src_resp_tag;
  logic [DW-1:0]     b_src_resp_data;
  logic              b_mem_req_valid, b_mem_req_store;
  logic [31:0]       b_mem_req_address, b_mem_req_tag;
  logic [DW-1:0]     b_mem_req_data;
  logic [MW-1:0]     b_mem_req_mask;
  logic              b_mem_resp_valid, b_mem_resp_ready;
  logic [31:0]       b_mem_resp_tag;
  logic              b_err_stray;

  cyclotron_mem_arbiter dut (
    .clock (clock), .reset (reset),
    .src_req_valid (src_req_valid), .src_req_ready (src_req_ready),
    .src_req_store (src_req_store), .src_req_address (src_req_address),
    .src_req_tag (src_req_tag), .src_req_data (src_req_data), .src_req_mask (src_req_mask),
    .src_resp_valid (src_resp_valid), .src_resp_ready (src_resp_ready),
    .src_resp_tag (src_resp_tag), .src_resp_data (src_resp_data),
    .mem_req_valid (mem_req_valid), .mem_req_ready (mem_req_ready),
    .mem_req_store (mem_req_store), .mem_req_address (mem_req_address),
    .mem_req_tag (mem_req_tag), .mem_req_data (mem_req_data), .mem_req_mask (mem_req_mask),
    .mem_resp_valid (mem_resp_valid), .mem_resp_ready (mem_resp_ready),
    .mem_resp_tag (mem_resp_tag), .mem_resp_data (mem_resp_data),
    .err_stray (err_stray)
  );

  cyclotron_mem_arbiter #(.NUM_SRCS(NB)) dut_b (
    .clock (clock), .reset (reset),
    .src_req_valid (b_src_req_valid), .src_req_ready (b_src_req_ready),
    .src_req_store (b_src_req_store), .src_req_address (b_src_req_address),
    .src_req_tag (b_src_req_tag), .src_req_data (b_src_req_data), .src_req_mask (b_src_req_mask),
    .src_resp_valid (b_src_resp_valid), .src_resp_ready (b_src_resp_ready),
    .src_resp_tag (b_src_resp_tag), .src_resp_data (b_src_resp_data),
    .mem_req_valid (b_mem_req_valid), .mem_req_ready (1'b1),
    .mem_req_store (b_mem_req_store), .mem_req_address (b_mem_req_address),
    .mem_req_tag (b_mem_req_tag), .mem_req_data (b_mem_req_data), .mem_req_mask (b_mem_req_mask),
    .mem_resp_valid (b_mem_resp_valid), .mem_resp_ready (b_mem_resp_ready),
    .mem_resp_tag (b_mem_resp_tag), .mem_resp_data ({DW{1'b0}}),
    .err_stray (b_err_stray)
  );

  typedef struct {
    logic [3:0] valid;
    logic [3:0] exp_ready;
    logic       exp_mvld;
    logic [1:0] exp_sid;
  } vec_t;

  vec_t vecs[11];
  int   n_checks = 0;
  int   n_err    = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset          = 1'b0;
    src_req_valid  = '0;
    mem_resp_valid = 1'b0;
    mem_req_ready  = 1'b1;
    tick();
    tick();
    reset = 1'b1;
  endtask

  initial begin
    logic [1:0]  s;
    logic [31:0] exp_tag;

    vecs[0]  = '{4'b1111, 4'b0001, 1'b0, 2'd0};
    vecs[1]  = '{4'b1111, 4'b0010, 1'b1, 2'd0};
    vecs[2]  = '{4'b1111, 4'b0100, 1'b1, 2'd1};
    vecs[3]  = '{4'b1111, 4'b1000, 1'b1, 2'd2};
    vecs[4]  = '{4'b1111, 4'b0001, 1'b1, 2'd3};
    vecs[5]  = '{4'b1010, 4'b0010, 1'b1, 2'd0};
    vecs[6]  = '{4'b1010, 4'b1000, 1'b1, 2'd1};
    vecs[7]  = '{4'b0100, 4'b0100, 1'b1, 2'd3};
    vecs[8]  = '{4'b0000, 4'b0000, 1'b1, 2'd2};
    vecs[9]  = '{4'b0011, 4'b0001, 1'b0, 2'd0};
    vecs[10] = '{4'b0000, 4'b0000, 1'b1, 2'd0};

    for (int k = 0; k < N; k++) begin
      src_req_address[k*32 +: 32] = 32'((k + 1) << 12);
      src_req_tag[k*8 +: 8]       = 8'(8'h10 + k);
      src_req_data[k*DW +: DW]    = {16{32'hD000_0000 | 32'(k)}};
      src_req_mask[k*MW +: MW]    = '1;
      src_req_store[k]            = 1'b0;
    end
    src_resp_ready    = '0;
    mem_resp_tag      = '0;
    mem_resp_data     = '0;
    b_src_req_valid   = '0;
    b_src_req_store   = '0;
    b_src_req_address = '0;
    b_src_req_tag     = '0;
    b_src_req_data    = '0;
    b_src_req_mask    = '0;
    b_src_resp_ready  = '0;
    b_mem_resp_valid  = 1'b0;
    b_mem_resp_tag    = '0;

    // Reset with every source requesting: nothing may be accepted.
    reset          = 1'b0;
    mem_req_ready  = 1'b1;
    mem_resp_valid = 1'b0;
    src_req_valid  = 4'b1111;
    tick();
    #1;
    chk("rst_src_req_ready", 64'(src_req_ready), 64'h0);
    tick();
    chk("rst_mem_req_valid", 64'(mem_req_valid), 64'h0);
    chk("rst_err_stray", 64'(err_stray), 64'h0);
    reset = 1'b1;

    // Round-robin table with mem_req_ready held high.
    for (int r = 0; r < 11; r++) begin
      src_req_valid = vecs[r].valid;
      #1;
      chk($sformatf("rr_ready[%0d]", r), 64'(src_req_ready), 64'(vecs[r].exp_ready));
      chk($sformatf("rr_mvld[%0d]", r), 64'(mem_req_valid), 64'(vecs[r].exp_mvld));
      if (vecs[r].exp_mvld) begin
        s       = vecs[r].exp_sid;
        exp_tag = {22'd0, s, 8'h10 + {6'd0, s}};
        chk($sformatf("rr_tag[%0d]", r), 64'(mem_req_tag), 64'(exp_tag));
        chk($sformatf("rr_addr[%0d]", r), 64'(mem_req_address), 64'({s + 3'd1, 12'h000}));
      end
      tick();
    end

    // Load from source 2 and its matching response.
    do_reset();
    src_req_tag[2*8 +: 8] = 8'h5A;
    src_req_valid = 4'b0100;
    #1;
    chk("ld_ready", 64'(src_req_ready), 64'h4);
    tick();
    src_req_valid = 4'b0000;
    #1;
    chk("ld_mem_req_tag", 64'(mem_req_tag), 64'h25A);
    mem_resp_valid = 1'b1;
    mem_resp_tag   = 32'h25A;
    mem_resp_data  = {16{32'hCAFE_0002}};
    src_resp_ready = 4'b0000;
    #1;
    chk("resp_bp_valid", 64'(src_resp_valid), 64'h4);
    chk("resp_bp_mem_ready", 64'(mem_resp_ready), 64'h0);
    src_resp_ready = 4'b0100;
    #1;
    chk("resp_valid", 64'(src_resp_valid), 64'h4);
    chk("resp_tag", 64'(src_resp_tag), 64'h5A);
    chk("resp_data", 64'(src_resp_data == {16{32'hCAFE_0002}}), 64'd1);
    chk("resp_mem_ready", 64'(mem_resp_ready), 64'h1);
    tick();
    #1;
    chk("resp_drained_valid", 64'(src_resp_valid), 64'h0);
    chk("resp_drained_stray", 64'(err_stray), 64'h0);
    mem_resp_valid = 1'b0;
    src_resp_ready = 4'b0000;

    // Source 1 fills its outstanding budget.
    do_reset();
    src_req_valid = 4'b0010;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk($sformatf("lim_ready[%0d]", i), 64'(src_req_ready), 64'h2);
      tick();
    end
    src_req_valid = 4'b1010;
    #1;
    chk("lim_stall_src3", 64'(src_req_ready), 64'h8);
    tick();
    src_req_valid  = 4'b0010;
    mem_resp_valid = 1'b1;
    mem_resp_tag   = 32'h100;
    src_resp_ready = 4'b0010;
    #1;
    chk("lim_stalled", 64'(src_req_ready), 64'h0);
    chk("lim_resp_valid", 64'(src_resp_valid), 64'h2);
    tick();
    mem_resp_valid = 1'b0;
    src_resp_ready = 4'b0000;
    #1;
    chk("lim_restored", 64'(src_req_ready), 64'h2);
    src_req_valid = 4'b0000;

    // Memory backpressure holds the payload steady.
    do_reset();
    src_req_store[0]          = 1'b1;
    src_req_address[0 +: 32]  = 32'hABCD_0000;
    src_req_tag[0 +: 8]       = 8'h33;
    src_req_data[0 +: DW]     = {16{32'h600D_F00D}};
    src_req_mask[0 +: MW]     = 64'h0000_0000_0000_00FF;
    src_req_valid             = 4'b0001;
    #1;
    chk("bp_grant0", 64'(src_req_ready), 64'h1);
    tick();
    mem_req_ready            = 1'b0;
    src_req_valid            = 4'b0011;
    src_req_address[0 +: 32] = 32'h0000_1111;
    src_req_tag[0 +: 8]      = 8'h44;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("bp_ready[%0d]", i), 64'(src_req_ready), 64'h0);
      chk($sformatf("bp_valid[%0d]", i), 64'(mem_req_valid), 64'h1);
      chk($sformatf("bp_addr[%0d]", i), 64'(mem_req_address), 64'hABCD_0000);
      chk($sformatf("bp_tag[%0d]", i), 64'(mem_req_tag), 64'h033);
      tick();
    end
    chk("bp_store", 64'(mem_req_store), 64'h1);
    chk("bp_mask", 64'(mem_req_mask), 64'hFF);
    chk("bp_data", 64'(mem_req_data == {16{32'h600D_F00D}}), 64'd1);
    mem_req_ready = 1'b1;
    #1;
    chk("bp_release_grant", 64'(src_req_ready), 64'h2);
    tick();
    src_req_valid = 4'b0000;
    #1;
    chk("bp_next_tag", 64'(mem_req_tag), 64'h111);
    tick();
    chk("bp_valid_clear", 64'(mem_req_valid), 64'h0);

    // Reset with four in flight, then a late response.
    do_reset();
    src_req_valid = 4'b1111;
    for (int i = 0; i < 4; i++) tick();
    src_req_valid = 4'b0000;
    reset = 1'b0;
    tick();
    reset          = 1'b1;
    mem_resp_valid = 1'b1;
    mem_resp_tag   = 32'h200;
    src_resp_ready = 4'b1111;
    #1;
    chk("late_resp_valid", 64'(src_resp_valid), 64'h0);
    chk("late_mem_ready", 64'(mem_resp_ready), 64'h1);
    chk("late_stray_pre", 64'(err_stray), 64'h0);
    tick();
    mem_resp_valid = 1'b0;
    src_resp_ready = 4'b0000;
    #1;
    chk("late_stray", 64'(err_stray), 64'h1);

    // Three-source instance: sid 3 names no source.
    do_reset();
    b_mem_resp_valid = 1'b1;
    b_mem_resp_tag   = 32'h300;
    b_src_resp_ready = 3'b111;
    #1;
    chk("oor_mem_ready", 64'(b_mem_resp_ready), 64'h1);
    chk("oor_resp_valid", 64'(b_src_resp_valid), 64'h0);
    chk("oor_stray_pre", 64'(b_err_stray), 64'h0);
    tick();
    b_mem_resp_valid = 1'b0;
    #1;
    chk("oor_stray_set", 64'(b_err_stray), 64'h1);
    for (int i = 0; i < 3; i++) tick();
    chk("oor_stray_sticky", 64'(b_err_stray), 64'h1);
    reset = 1'b0;
    tick();
    chk("oor_stray_cleared", 64'(b_err_stray), 64'h0);
    reset = 1'b1;

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
